// File: rtl/tt_code_pkg.sv
// Shared constants and the code-to-word decode function for tt_um_code_decoder.
//   CODE_NONE     : byte meaning "no input active"
//   CODE_MAX_IDX  : highest legal index code
//   ERR_PATTERN   : word produced for any illegal code byte
//   DEC_WIDTH     : width of the decoded word
//   decode()      : index k -> bit 15 plus one-hot bit k; CODE_NONE -> 0;
//                   anything else -> ERR_PATTERN
package tt_code_pkg;

  localparam int              DEC_WIDTH    = 16;
  localparam logic [7:0]      CODE_NONE    = 8'hF0;
  localparam logic [7:0]      CODE_MAX_IDX = 8'h0E;
  localparam logic [DEC_WIDTH-1:0] ERR_PATTERN = 16'hFFFF;

  // Bit 15 flags "a code is present"; it is the inverse of the 16-to-4
  // priority encoder, whose legal outputs are exactly indices 0..14.
  function automatic logic [DEC_WIDTH-1:0] decode(input logic [7:0] code);
    logic [DEC_WIDTH-1:0] word;
    word = ERR_PATTERN;
    if (code == CODE_NONE) begin
      word = '0;
    end else if (code <= CODE_MAX_IDX) begin
      word              = '0;
      word[DEC_WIDTH-1] = 1'b1;
      word[code[3:0]]   = 1'b1;
    end
    return word;
  endfunction

endpackage

// File: rtl/code_debounce.sv
// Two-flop input synchronizer plus stability qualifier.
//   clk, rst_n : clock, asynchronous active-low reset
//   code_in    : raw asynchronous code byte
//   code_s     : synchronized code (second synchronizer stage)
//   accept     : one-cycle pulse, high on the edge where code_s has been
//                stable long enough to be loaded downstream
module code_debounce
  import tt_code_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] code_in,
  output logic [7:0] code_s,
  output logic       accept
);

  localparam logic [2:0] CNT_SAT = 3'(STABLE_CYCLES);
  localparam logic [2:0] CNT_ACC = 3'(STABLE_CYCLES - 1);

  logic [7:0] sync_p0;
  logic [7:0] prev;
  logic [2:0] cnt;

  // Resetting cnt to the saturation value means the idle CODE_NONE that
  // follows reset is never treated as a fresh code to accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= CODE_NONE;
      code_s  <= CODE_NONE;
      prev    <= CODE_NONE;
      cnt     <= CNT_SAT;
    end else begin
      // synchronizer stage 0 -> stage 1 -> previous-sample register
      sync_p0 <= code_in;
      code_s  <= sync_p0;
      prev    <= code_s;
      if (code_s != prev) begin
        cnt <= '0;
      end else if (cnt != CNT_SAT) begin
        cnt <= cnt + 3'd1;
      end
    end
  end

  // Fires once per stable run: cnt steps past CNT_ACC on this same edge and
  // then sits at CNT_SAT until code_s changes.
  assign accept = (code_s == prev) && (cnt == CNT_ACC);

endmodule

// File: rtl/tt_um_code_decoder.sv
// Debounced code-byte to 16-bit word decoder.
//   clk, rst_n : clock, asynchronous active-low reset
//   ena        : power-good indicator (unused)
//   ui_in      : code byte (0x00..0x0E index, 0xF0 none, else error)
//   uio_in     : unused
//   uo_out     : decoded word [7:0]
//   uio_out    : decoded word [15:8]
//   uio_oe     : all bidirectional pins driven as outputs
module tt_um_code_decoder
  import tt_code_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic [7:0]           code_s;
  logic                 accept;
  logic [DEC_WIDTH-1:0] word_q;
  logic                 unused_inputs;

  assign unused_inputs = &{1'b0, ena, uio_in};

  code_debounce #(
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_debounce (
    .clk    (clk),
    .rst_n  (rst_n),
    .code_in(ui_in),
    .code_s (code_s),
    .accept (accept)
  );

  // Output register: loads only on accept so an error word or the last
  // valid word persists until the next qualified code.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q <= '0;
    end else if (accept) begin
      word_q <= decode(code_s);
    end
  end

  assign uo_out  = word_q[7:0];
  assign uio_out = word_q[15:8];
  assign uio_oe  = 8'hFF;

endmodule

// File: tb/tb_tt_um_code_decoder.sv
// Directed bench for tt_um_code_decoder with STABLE_CYCLES = 4.
module tb_tt_um_code_decoder;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int tests = 0;
  int fails = 0;

  tt_um_code_decoder #(.STABLE_CYCLES(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uio_in (uio_in),
    .uo_out (uo_out),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  code;
    logic [15:0] word;
  } vec_t;

  vec_t vecs[18];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_word(input string name, input logic [15:0] exp);
    check(name, {uio_out, uo_out}, exp);
  endtask

  initial begin
    // Decode vectors: index sweep, error bytes, then back to none.
    for (int k = 0; k < 15; k++) begin
      vecs[k].code = 8'(k);
      vecs[k].word = 16'h8000 | (16'h0001 << k);
    end
    vecs[15].code = 8'h0F; vecs[15].word = 16'hFFFF;
    vecs[16].code = 8'h55; vecs[16].word = 16'hFFFF;
    vecs[17].code = 8'hF0; vecs[17].word = 16'h0000;

    ena    = 1'b1;
    uio_in = 8'hA5;
    ui_in  = 8'hF0;
    rst_n  = 1'b0;
    #1;
    check_word("reset_word", 16'h0000);
    check("reset_oe", {8'h00, uio_oe}, 16'h00FF);
    tick();
    tick();
    rst_n = 1'b1;

    // Idle after reset: nothing accepted for 20 cycles.
    for (int i = 0; i < 20; i++) begin
      uio_in = 8'($urandom);
      tick();
      check_word("idle_word", 16'h0000);
      check("idle_oe", {8'h00, uio_oe}, 16'h00FF);
    end

    // Latency: 0x05 sampled first at E0, output changes exactly at E0+6.
    ui_in = 8'h05;
    for (int e = 0; e <= 6; e++) begin
      tick();
      check_word($sformatf("latency_e%0d", e), (e == 6) ? 16'h8020 : 16'h0000);
    end
    for (int i = 0; i < 4; i++) tick();

    // Table sweep: old value still held after 5 edges, new one after 10.
    begin
      logic [15:0] last;
      last = 16'h8020;
      for (int v = 0; v < 18; v++) begin
        ui_in  = vecs[v].code;
        uio_in = 8'($urandom);
        for (int i = 0; i < 5; i++) tick();
        check_word($sformatf("hold_prev_%02h", vecs[v].code), last);
        for (int i = 0; i < 5; i++) tick();
        check_word($sformatf("decode_%02h", vecs[v].code), vecs[v].word);
        last = vecs[v].word;
      end
    end

    // Steady 0x07, then a 3-sample and a 4-sample glitch to 0x02: rejected.
    ui_in = 8'h07;
    for (int i = 0; i < 10; i++) tick();
    check_word("steady_07", 16'h8080);
    for (int g = 3; g <= 4; g++) begin
      ui_in = 8'h02;
      for (int i = 0; i < g; i++) tick();
      ui_in = 8'h07;
      for (int i = 0; i < 12; i++) begin
        tick();
        check_word($sformatf("glitch%0d_hold", g), 16'h8080);
      end
    end

    // A 5-sample run of 0x02 is the shortest that is accepted.
    ui_in = 8'h02;
    for (int i = 0; i < 5; i++) tick();   // edges E0..E0+4
    ui_in = 8'h07;
    tick();                                // E0+5
    check_word("run5_before", 16'h8080);
    tick();                                // E0+6
    check_word("run5_accept", 16'h8004);
    for (int i = 0; i < 4; i++) tick();    // E0+10
    check_word("run5_hold", 16'h8004);
    tick();                                // E0+11: 0x07 re-qualified
    check_word("return_07", 16'h8080);

    // Reset mid-qualification discards 0x09; latency restarts after release.
    ui_in = 8'h09;
    for (int i = 0; i < 3; i++) tick();
    rst_n = 1'b0;
    #1;
    check_word("midreset_word", 16'h0000);
    tick();
    check_word("midreset_hold", 16'h0000);
    tick();
    rst_n = 1'b1;
    for (int e = 0; e <= 6; e++) begin
      tick();
      check_word($sformatf("postreset_e%0d", e), (e == 6) ? 16'h8200 : 16'h0000);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tt_um_code_decoder.md
TT_UM_CODE_DECODER -- requirements
Module: tt_um_code_decoder

Interface
REQ-001 Parameter STABLE_CYCLES, default 4, range 1..7: consecutive matching synchronized samples required before a code is accepted.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 ena  input  1  design-powered indicator; ignored by all logic.
REQ-005 ui_in  input  8  encoded code byte: 0x00..0x0E = index; 0xF0 = "no input active".
REQ-006 uio_in  input  8  unused; no effect on any output.
REQ-007 uo_out  output  8  decoded word bits [7:0].
REQ-008 uio_out  output  8  decoded word bits [15:8].
REQ-009 uio_oe  output  8  constant 0xFF in and out of reset.

Function
REQ-010 ui_in shall pass through a 2-flop synchronizer; the second stage is code_s; a third register prev holds code_s from the previous cycle.
REQ-011 Stability counter cnt (3 bits): cleared to 0 when code_s != prev; otherwise incremented, saturating at STABLE_CYCLES.
REQ-012 Accept event: code_s == prev and cnt == STABLE_CYCLES-1; the 16-bit output register shall load decode(code_s) on that edge only, at most once per stable run.
REQ-013 Latency: for a new value first sampled on edge E0 and held, the output shall change on edge E0+STABLE_CYCLES+2 and at no earlier edge.
REQ-014 A value held fewer than STABLE_CYCLES+1 samples at code_s shall never be accepted; the output shall hold its previous value.
REQ-015 decode(k), k in 0x00..0x0E: bit 15 = 1, bit k = 1, all other bits 0 (e.g. 0x03 -> 0x8008, 0x0E -> 0xC000).
REQ-016 decode(0xF0) = 0x0000.
REQ-017 decode(any other byte, including 0x0F) = 0xFFFF error pattern; the error pattern shall be held until the next accept.
REQ-018 Re-acceptance of a code equal to the current one (after a rejected glitch) shall reload an identical value with no visible output change.
REQ-019 Output shall be driven purely from registers; no combinational path from ui_in to uo_out/uio_out.

Reset
REQ-020 rst_n low shall immediately force output register 0x0000, both synchronizer stages and prev to 0xF0, cnt to STABLE_CYCLES.
REQ-021 After rst_n release with ui_in at 0xF0, no accept event shall occur and the output shall stay 0x0000.
REQ-022 Reset asserted mid-qualification shall discard the pending code; after release the code must satisfy REQ-013 again, measured from the first post-reset sampling edge.

Structure
REQ-023 Package tt_code_pkg shall hold CODE_NONE (0xF0), CODE_MAX_IDX (0x0E), ERR_PATTERN (0xFFFF), DEC_WIDTH (16), and a decode function implementing REQ-015..REQ-017.
REQ-024 Synchronizer, prev register and stability counter shall form one sub-module, code_debounce, that outputs code_s and a one-cycle accept pulse; the top module holds the output register and the I/O mapping.
REQ-025 The decode function shall be bit-exact inverse of the team's 16-to-4 priority encoder on every legal code byte that encoder produces.

Verification
REQ-026 Reset, ui_in=0xF0 for 20 cycles -> uo_out=0x00, uio_out=0x00, uio_oe=0xFF throughout.
REQ-027 ui_in 0xF0 -> 0x05 held from edge E0 -> {uio_out,uo_out} = 0x0000 through edge E0+5, = 0x8020 after edge E0+6 (STABLE_CYCLES=4).
REQ-028 Sweep ui_in 0x00..0x0E, each held 10 cycles -> outputs 0x8001, 0x8002, ... 0xC000 in order, one-hot below bit 15.
REQ-029 ui_in steady 0x07 (output 0x8080), 3-cycle glitch to 0x02, back to 0x07 -> output remains 0x8080 with no intermediate value.
REQ-030 ui_in = 0x0F then 0x55, each held 10 cycles -> output 0xFFFF; then 0xF0 held -> 0x0000.
REQ-031 ui_in 0x09 held 3 cycles, rst_n pulsed low 2 cycles, 0x09 still held -> output 0x0000 during reset, 0x8200 exactly STABLE_CYCLES+2 edges after the first post-reset sampling edge.
